// File: rtl/parity_serial_sched_if.sv
// parity_serial_sched_if: request/grant and serial-parity bundle.
// PARITY_SCHED_CHECK_EN adds exp_odd / par_err.
interface parity_serial_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  ser_bit;
  logic                  ser_valid;
  logic                  done;
  logic [IW-1:0]         done_id;
  logic                  ones_odd;
  logic                  zeros_odd;
`ifdef PARITY_SCHED_CHECK_EN
  logic [NREQ-1:0]       exp_odd;
  logic                  par_err;
`endif

  modport master (
    output req, data,
`ifdef PARITY_SCHED_CHECK_EN
    output exp_odd,
    input  par_err,
`endif
    input  gnt, busy, ser_bit, ser_valid,
    input  done, done_id, ones_odd, zeros_odd
  );

  modport slave (
    input  req, data,
`ifdef PARITY_SCHED_CHECK_EN
    input  exp_odd,
    output par_err,
`endif
    output gnt, busy, ser_bit, ser_valid,
    output done, done_id, ones_odd, zeros_odd
  );
endinterface

// File: rtl/parity_serial_sched.sv
// parity_serial_sched: round-robin shared bit-serial parity tracker.
// PARITY_SCHED_CHECK_EN adds a per-frame expected-parity check.
module parity_serial_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  parity_serial_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [IW-1:0]    pick;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             ones_acc;
  logic             zeros_acc;
  logic [NREQ-1:0]  gnt_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;
  logic [IW-1:0]    done_id_q;
  logic             ones_q;
  logic             zeros_q;
  logic             bit_now;
`ifdef PARITY_SCHED_CHECK_EN
  logic             exp_q;
  logic             err_q;
`endif

  assign bit_now = shreg[0];

  // First set request at or after ptr, wrapping.
  always_comb begin
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr) + k) % NREQ])
        pick = IW'((int'(ptr) + k) % NREQ);
    end
  end

  // Scheduler FSM with serializer and parity accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      shreg     <= '0;
      cnt       <= '0;
      ones_acc  <= 1'b0;
      zeros_acc <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      ones_q    <= 1'b0;
      zeros_q   <= 1'b0;
`ifdef PARITY_SCHED_CHECK_EN
      exp_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req != '0) begin
            win       <= pick;
            gnt_q     <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            shreg     <= bus.data[int'(pick)*WIDTH +: WIDTH];
            cnt       <= '0;
            ones_acc  <= 1'b0;
            zeros_acc <= 1'b0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b1;
            state     <= SHIFT;
`ifdef PARITY_SCHED_CHECK_EN
            exp_q     <= bus.exp_odd[pick];
`endif
          end
        end
        SHIFT: begin
          ones_acc  <= ones_acc ^ bit_now;
          zeros_acc <= zeros_acc ^ ~bit_now;
          shreg     <= shreg >> 1;
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            ones_q    <= ones_acc ^ bit_now;
            zeros_q   <= zeros_acc ^ ~bit_now;
            valid_q   <= 1'b0;
            done_q    <= 1'b1;
            done_id_q <= win;
            state     <= REPORT;
`ifdef PARITY_SCHED_CHECK_EN
            err_q     <= (ones_acc ^ bit_now) != exp_q;
`endif
          end
        end
        REPORT: begin
          done_q <= 1'b0;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          ptr    <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          state  <= IDLE;
`ifdef PARITY_SCHED_CHECK_EN
          err_q  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.ser_bit   = bit_now;
  assign bus.ser_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.ones_odd  = ones_q;
  assign bus.zeros_odd = zeros_q;
`ifdef PARITY_SCHED_CHECK_EN
  assign bus.par_err   = err_q;
`endif
endmodule

// File: tb/tb_parity_serial_sched.sv
// tb_parity_serial_sched: directed table-driven bench.
// Covers frames, round-robin, mid-frame reset, ignored inputs.
module tb_parity_serial_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  parity_serial_sched_if #(.NREQ(4), .WIDTH(8)) bus ();

  parity_serial_sched #(.NREQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] w;
    logic       eo;
    logic       ez;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.gnt == '0 && t < 20);
    if (bus.gnt == '0) chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_frame(input int id, input logic [7:0] w,
                          input logic eo, input logic ez,
                          output logic pe);
    logic [7:0] got;
    int nv;
    got = '0;
    nv = 0;
    pe = 1'b0;
    bus.data[id*8 +: 8] = w;
    bus.req = 4'(1 << id);
    wait_gnt("frame");
    chk("gnt", 32'(bus.gnt), 32'(1 << id));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      got[i] = bus.ser_bit;
      if (bus.ser_valid) nv++;
      if (bus.done) chk("early_done", 32'd1, 32'd0);
    end
    chk("ser_bits", 32'(got), 32'(w));
    chk("ser_valid_cnt", 32'(nv), 32'd8);
    @(negedge clk);
    chk("done", 32'(bus.done), 32'd1);
    chk("done_id", 32'(bus.done_id), 32'(id));
    chk("ones_odd", 32'(bus.ones_odd), 32'(eo));
    chk("zeros_odd", 32'(bus.zeros_odd), 32'(ez));
    chk("invariant", 32'(bus.ones_odd ^ bus.zeros_odd), 32'd0);
    chk("ser_valid_rep", 32'(bus.ser_valid), 32'd0);
`ifdef PARITY_SCHED_CHECK_EN
    pe = bus.par_err;
`endif
    bus.req = '0;
    @(negedge clk);
    chk("done_drop", 32'(bus.done), 32'd0);
    chk("gnt_drop", 32'(bus.gnt), 32'd0);
    chk("busy_drop", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int ids [$];
    int tms [$];
    int cyc;
    int bad_oh;
    int exp_ids [5];
    logic pe;
    logic [7:0] got;

    tbl[0] = '{0, 8'b1011_0100, 1'b0, 1'b0};
    tbl[1] = '{2, 8'h07, 1'b1, 1'b1};
    tbl[2] = '{2, 8'h01, 1'b1, 1'b1};
    tbl[3] = '{2, 8'h03, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{3, 8'hFF, 1'b0, 1'b0};
    exp_ids = '{0, 1, 2, 3, 0};

    bus.req = '0;
    bus.data = '0;
`ifdef PARITY_SCHED_CHECK_EN
    bus.exp_odd = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.ser_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_id", 32'(bus.done_id), 32'd0);
    chk("rst_ones", 32'(bus.ones_odd), 32'd0);
    chk("rst_zeros", 32'(bus.zeros_odd), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_gnt", 32'(bus.gnt), 32'd0);

    for (int i = 0; i < 6; i++)
      do_frame(tbl[i].id, tbl[i].w, tbl[i].eo, tbl[i].ez, pe);

    // Round-robin with all requesters active, ptr back at 0.
    cyc = 0;
    bad_oh = 0;
    bus.data = {8'h11, 8'h22, 8'h33, 8'h44};
    bus.req = 4'hF;
    while (ids.size() < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != '0 && !$onehot(bus.gnt)) bad_oh++;
      if (bus.done) begin
        ids.push_back(int'(bus.done_id));
        tms.push_back(cyc);
        chk("rr_gnt_id", 32'(bus.gnt), 32'(1 << bus.done_id));
        if (ids.size() == 5) bus.req = '0;
      end
    end
    bus.req = '0;
    chk("rr_count", 32'(ids.size()), 32'd5);
    chk("rr_onehot", 32'(bad_oh), 32'd0);
    for (int i = 0; i < ids.size(); i++)
      chk("rr_order", 32'(ids[i]), 32'(exp_ids[i]));
    for (int i = 1; i < tms.size(); i++)
      chk("rr_gap", 32'(tms[i] - tms[i-1]), 32'd10);
    repeat (2) @(negedge clk);
    chk("rr_idle", 32'(bus.gnt), 32'd0);

    // Mid-frame reset on an all-ones word.
    bus.data[7:0] = 8'hFF;
    bus.req = 4'b0001;
    wait_gnt("mrst");
    chk("mrst_gnt", 32'(bus.gnt), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_gnt0", 32'(bus.gnt), 32'd0);
    chk("mrst_valid", 32'(bus.ser_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_ptr", 32'(dut.ptr), 32'd0);
    chk("mrst_ones", 32'(bus.ones_odd), 32'd0);
    bus.req = '0;
    @(negedge clk);
    chk("mrst_done2", 32'(bus.done), 32'd0);
    rst = 1'b0;
    do_frame(1, 8'h3C, 1'b0, 1'b0, pe);

    // Request dropped and data changed mid-frame.
    bus.data[15:8] = 8'h01;
    bus.req = 4'b0010;
    wait_gnt("ign");
    chk("ign_gnt", 32'(bus.gnt), 32'd2);
    got = '0;
    got[0] = bus.ser_bit;
    @(negedge clk);
    got[1] = bus.ser_bit;
    bus.req = '0;
    bus.data[15:8] = 8'hFE;
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      got[i] = bus.ser_bit;
    end
    chk("ign_bits", 32'(got), 32'h01);
    @(negedge clk);
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_id", 32'(bus.done_id), 32'd1);
    chk("ign_ones", 32'(bus.ones_odd), 32'd1);
    chk("ign_zeros", 32'(bus.zeros_odd), 32'd1);
    cyc = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.gnt != '0 || bus.done) cyc++;
    end
    chk("ign_no_regnt", 32'(cyc), 32'd0);
    chk("ign_hold_ones", 32'(bus.ones_odd), 32'd1);

`ifdef PARITY_SCHED_CHECK_EN
    bus.exp_odd = 4'b0000;
    do_frame(0, 8'h07, 1'b1, 1'b1, pe);
    chk("par_err_hit", 32'(pe), 32'd1);
    chk("par_err_clr", 32'(bus.par_err), 32'd0);
    bus.exp_odd = 4'b0001;
    do_frame(0, 8'h07, 1'b1, 1'b1, pe);
    chk("par_err_ok", 32'(pe), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
